core_op_ctrl: RTL

//   Top-level sequencer of the image core. Pulses op_ready, accepts one 4-bit

---
 rtl/core_pkg.sv | 46 ++++
 rtl/core_op_ctrl_if.sv | 11 +
 rtl/core_load_agu.sv | 22 ++
 rtl/core_op_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the image-core op sequencer: opcodes, FSM states,
// depth and engine select codes, load geometry.
package core_pkg;

   localparam int N_BYTES = 2048;
   localparam int ADDR_W  = $clog2(N_BYTES);

   localparam logic [2:0] ORG_MAX = 3'd6;

   localparam logic [3:0] OP_LOAD     = 4'd0;
   localparam logic [3:0] OP_RIGHT    = 4'd1;
   localparam logic [3:0] OP_LEFT     = 4'd2;
   localparam logic [3:0] OP_UP       = 4'd3;
   localparam logic [3:0] OP_DOWN     = 4'd4;
   localparam logic [3:0] OP_DEPTH_DN = 4'd5;
   localparam logic [3:0] OP_DEPTH_UP = 4'd6;
   localparam logic [3:0] OP_DISPLAY  = 4'd7;
   localparam logic [3:0] OP_CONV     = 4'd8;
   localparam logic [3:0] OP_MEDIAN   = 4'd9;
   localparam logic [3:0] OP_SOBEL    = 4'd10;

   localparam logic [1:0] DEPTH_8  = 2'd0;
   localparam logic [1:0] DEPTH_16 = 2'd1;
   localparam logic [1:0] DEPTH_32 = 2'd2;

   localparam logic [1:0] ENG_DISPLAY = 2'd0;
   localparam logic [1:0] ENG_CONV    = 2'd1;
   localparam logic [1:0] ENG_MEDIAN  = 2'd2;
   localparam logic [1:0] ENG_SOBEL   = 2'd3;

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_IDLE,
      ST_WAIT_OP,
      ST_LOAD,
      ST_EXEC
   } state_t;

   // Engine opcodes are contiguous, so the select code is the offset from OP_DISPLAY.
   function automatic logic [1:0] eng_of_op(input logic [3:0] op);
      logic [3:0] d;
      d = op - OP_DISPLAY;
      return d[1:0];
   endfunction

endpackage

// File: rtl/core_op_ctrl_if.sv
// Opcode and load-byte handshake between the core ports and the sequencer.
interface core_op_ctrl_if;
   logic       op_valid;
   logic [3:0] op_mode;
   logic       op_ready;
   logic       in_valid;
   logic       in_ready;

   modport master (output op_valid, op_mode, in_valid, input op_ready, in_ready);
   modport slave  (input op_valid, op_mode, in_valid, output op_ready, in_ready);
endinterface

// File: rtl/core_load_agu.sv
// Load byte counter / SRAM address generator with terminal-count flag.
module core_load_agu
   import core_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   output logic [ADDR_W-1:0] count,
   output logic              last
);

   always_ff @(posedge clk) begin
      if (!rst_n || clr)
         count <= '0;
      else if (en)
         count <= count + ADDR_W'(1);
   end

   assign last = (count == ADDR_W'(N_BYTES - 1));

endmodule

// File: rtl/core_op_ctrl.sv
// Top-level op sequencer: opcode handshake, SRAM load, origin/depth regs, engine start.
// Optional build macro CORE_OP_ILLEGAL_FLAG_EN adds the sticky op_err output.
module core_op_ctrl
   import core_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   core_op_ctrl_if.slave     op_if,
   output logic              load_we,
   output logic [ADDR_W-1:0] load_addr,
   output logic              eng_start,
   output logic [1:0]        eng_sel,
   input  logic              eng_done,
   output logic [2:0]        org_x,
   output logic [2:0]        org_y,
   output logic [1:0]        depth
`ifdef CORE_OP_ILLEGAL_FLAG_EN
   ,
   output logic              op_err
`endif
);

   state_t            state;
   logic [ADDR_W-1:0] ld_count;
   logic              ld_last;
   logic              ld_accept;
   logic              ld_clr;

   assign ld_accept = (state == ST_LOAD) && op_if.in_valid && op_if.in_ready;
   assign ld_clr    = (state != ST_LOAD);

   core_load_agu u_agu (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (ld_clr),
      .en    (ld_accept),
      .count (ld_count),
      .last  (ld_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= ST_BOOT;
         op_if.op_ready <= 1'b0;
         op_if.in_ready <= 1'b0;
         load_we        <= 1'b0;
         load_addr      <= '0;
         eng_start      <= 1'b0;
         eng_sel        <= ENG_DISPLAY;
         org_x          <= '0;
         org_y          <= '0;
         depth          <= DEPTH_32;
`ifdef CORE_OP_ILLEGAL_FLAG_EN
         op_err         <= 1'b0;
`endif
      end else begin
         op_if.op_ready <= 1'b0;
         eng_start      <= 1'b0;
         load_we        <= 1'b0;
         case (state)
            ST_BOOT: begin
               state          <= ST_IDLE;
               op_if.op_ready <= 1'b1;
            end
            ST_IDLE: state <= ST_WAIT_OP;
            ST_WAIT_OP: begin
               if (op_if.op_valid) begin
                  // Register ops and illegal ops return to IDLE; LOAD/EXEC override below.
                  state          <= ST_IDLE;
                  op_if.op_ready <= 1'b1;
                  case (op_if.op_mode)
                     OP_LOAD: begin
                        state          <= ST_LOAD;
                        op_if.op_ready <= 1'b0;
                        op_if.in_ready <= 1'b1;
                     end
                     OP_RIGHT:    if (org_x != ORG_MAX)  org_x <= org_x + 3'd1;
                     OP_LEFT:     if (org_x != 3'd0)     org_x <= org_x - 3'd1;
                     OP_UP:       if (org_y != 3'd0)     org_y <= org_y - 3'd1;
                     OP_DOWN:     if (org_y != ORG_MAX)  org_y <= org_y + 3'd1;
                     OP_DEPTH_DN: if (depth != DEPTH_8)  depth <= depth - 2'd1;
                     OP_DEPTH_UP: if (depth != DEPTH_32) depth <= depth + 2'd1;
                     OP_DISPLAY, OP_CONV, OP_MEDIAN, OP_SOBEL: begin
                        state          <= ST_EXEC;
                        op_if.op_ready <= 1'b0;
                        eng_start      <= 1'b1;
                        eng_sel        <= eng_of_op(op_if.op_mode);
                     end
                     default: begin
`ifdef CORE_OP_ILLEGAL_FLAG_EN
                        op_err <= 1'b1;
`endif
                     end
                  endcase
               end
            end
            ST_LOAD: begin
               if (ld_accept) begin
                  load_we   <= 1'b1;
                  load_addr <= ld_count;
                  // A fresh map invalidates the viewing window.
                  if (ld_last) begin
                     state          <= ST_IDLE;
                     op_if.op_ready <= 1'b1;
                     op_if.in_ready <= 1'b0;
                     org_x          <= '0;
                     org_y          <= '0;
                     depth          <= DEPTH_32;
`ifdef CORE_OP_ILLEGAL_FLAG_EN
                     op_err         <= 1'b0;
`endif
                  end
               end
            end
            ST_EXEC: begin
               if (eng_done) begin
                  state          <= ST_IDLE;
                  op_if.op_ready <= 1'b1;
               end
            end
            default: state <= ST_BOOT;
         endcase
      end
   end

endmodule
